// File: rtl/data_path_if.sv
// Control strobes and I/O data between a control unit (master) and the
// single-bus datapath (slave).
interface data_path_if;
  logic        PCout, Zlowout, MDRout, Rout, BAout, InPortout, Csignout;
  logic        PCin, IRin, Yin, MARin, MDRin, Zlowin, Zhighin, Rin, CONin, Out_Portin;
  logic        MAR_clear, MD_read, Read, Write;
  logic        Gra, Grb;
  logic        IncPC, ADD, AND;
  logic        Strobe;
  logic [31:0] INPUT_UNIT;
  logic [31:0] OUTPUT_UNIT;
  logic        CONFF;
  logic        BRANCH;

  modport master (
    output PCout, Zlowout, MDRout, Rout, BAout, InPortout, Csignout,
    output PCin, IRin, Yin, MARin, MDRin, Zlowin, Zhighin, Rin, CONin, Out_Portin,
    output MAR_clear, MD_read, Read, Write, Gra, Grb, IncPC, ADD, AND, Strobe,
    output INPUT_UNIT,
    input  OUTPUT_UNIT, CONFF, BRANCH
  );

  modport slave (
    input  PCout, Zlowout, MDRout, Rout, BAout, InPortout, Csignout,
    input  PCin, IRin, Yin, MARin, MDRin, Zlowin, Zhighin, Rin, CONin, Out_Portin,
    input  MAR_clear, MD_read, Read, Write, Gra, Grb, IncPC, ADD, AND, Strobe,
    input  INPUT_UNIT,
    output OUTPUT_UNIT, CONFF, BRANCH
  );
endinterface

// File: rtl/data_path.sv
// 32-bit single-bus CPU datapath: R0-R15, PC, IR, Y, 64-bit Z, MAR, MDR, CON,
// I/O ports and a 512x32 RAM, all steered by one-hot control strobes.
module data_path #(
  parameter string      MEM_INIT  = "",
  parameter logic [4:0] BR_OPCODE = 5'b10010
) (
  input logic        clock,
  input logic        clear,
  data_path_if.slave dp
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] y_q, y_d;
  logic [63:0] z_q, z_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] inport_q, inport_d;
  logic [31:0] outport_q, outport_d;
  logic        con_q, con_d;
  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] mem_q [512];

  logic [31:0] bus;
  logic [31:0] csign;
  logic [31:0] ram_rdata;
  logic [63:0] alu_c;
  logic [3:0]  field;
  logic        cond;
  logic        mar_unused;

  // Only the low 9 MAR bits address the RAM; higher addresses alias.
  assign ram_rdata  = mem_q[mar_q[8:0]];
  assign mar_unused = ^mar_q[31:9];

  always_ff @(posedge clock) begin
    if (clear && dp.Write) mem_q[mar_q[8:0]] <= mdr_q;
  end

  always_comb begin
    field = 4'd0;
    if (dp.Gra)      field = ir_q[26:23];
    else if (dp.Grb) field = ir_q[22:19];
  end

  assign csign = {{13{ir_q[18]}}, ir_q[18:0]};

  always_comb begin
    bus = '0;
    if (dp.PCout)                  bus = pc_q;
    else if (dp.Zlowout)           bus = z_q[31:0];
    else if (dp.MDRout)            bus = mdr_q;
    else if (dp.InPortout)         bus = inport_q;
    else if (dp.Rout || dp.BAout)  bus = (!dp.Rout && field == 4'd0) ? '0 : r_q[field];
    else if (dp.Csignout)          bus = csign;
  end

  always_comb begin
    alu_c = '0;
    if (dp.IncPC)    alu_c = {32'd0, bus + 32'd1};
    else if (dp.ADD) alu_c = {31'd0, {1'b0, y_q} + {1'b0, bus}};
    else if (dp.AND) alu_c = {32'd0, y_q & bus};
  end

  always_comb begin
    cond = 1'b0;
    case (ir_q[20:19])
      2'b00: cond = (bus == 32'd0);
      2'b01: cond = (bus != 32'd0);
      2'b10: cond = ~bus[31];
      2'b11: cond = bus[31];
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    y_d       = y_q;
    z_d       = z_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    inport_d  = inport_q;
    outport_d = outport_q;
    con_d     = con_q;
    r_d       = r_q;

    if (dp.PCin)       pc_d = bus;
    if (dp.IRin)       ir_d = bus;
    if (dp.Yin)        y_d  = bus;
    if (dp.Zlowin)     z_d[31:0]  = alu_c[31:0];
    if (dp.Zhighin)    z_d[63:32] = alu_c[63:32];
    if (dp.MAR_clear)  mar_d = '0;
    else if (dp.MARin) mar_d = bus;
    // RAM data is asynchronous, so a combined Read/Write edge captures the old word.
    if (dp.MDRin) begin
      if (!dp.MD_read)   mdr_d = bus;
      else if (dp.Read)  mdr_d = ram_rdata;
    end
    if (dp.Strobe)     inport_d  = dp.INPUT_UNIT;
    if (dp.Out_Portin) outport_d = bus;
    if (dp.CONin)      con_d     = cond;
    if (dp.Rin)        r_d[field] = bus;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_q      <= '0;
      ir_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
      r_q       <= '{default: '0};
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      y_q       <= y_d;
      z_q       <= z_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      inport_q  <= inport_d;
      outport_q <= outport_d;
      con_q     <= con_d;
      r_q       <= r_d;
    end
  end

  assign dp.OUTPUT_UNIT = outport_q;
  assign dp.CONFF       = con_q;
  assign dp.BRANCH      = con_q && (ir_q[31:27] == BR_OPCODE);

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: a table of control-word vectors whose expectations go
// through a scoreboard queue, plus reset, read/write and async-clear sequences.
module tb_data_path;
  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  data_path_if dpi ();
  data_path #(.MEM_INIT(""), .BR_OPCODE(5'b10010)) dut (
    .clock(clock),
    .clear(clear),
    .dp   (dpi)
  );

  localparam logic [26:0] PCO  = 27'd1 << 0,  ZLO  = 27'd1 << 1,  MDRO = 27'd1 << 2;
  localparam logic [26:0] RO   = 27'd1 << 3,  BAO  = 27'd1 << 4,  INO  = 27'd1 << 5;
  localparam logic [26:0] CSO  = 27'd1 << 6,  PCIN = 27'd1 << 7,  IRIN = 27'd1 << 8;
  localparam logic [26:0] YIN  = 27'd1 << 9,  MARI = 27'd1 << 10, MDRI = 27'd1 << 11;
  localparam logic [26:0] ZLI  = 27'd1 << 12, ZHI  = 27'd1 << 13, RIN  = 27'd1 << 14;
  localparam logic [26:0] CONI = 27'd1 << 15, OPI  = 27'd1 << 16, MCLR = 27'd1 << 17;
  localparam logic [26:0] MDRD = 27'd1 << 18, RD   = 27'd1 << 19, WR   = 27'd1 << 20;
  localparam logic [26:0] GRA  = 27'd1 << 21, GRB  = 27'd1 << 22, INC  = 27'd1 << 23;
  localparam logic [26:0] ADDO = 27'd1 << 24, ANDO = 27'd1 << 25, STB  = 27'd1 << 26;

  typedef enum {O_NONE, O_PC, O_IR, O_Y, O_Z, O_MAR, O_MDR, O_OUT, O_CON, O_BR, O_REG, O_BUS} obs_e;

  typedef struct {
    string       name;
    logic [26:0] ctl;
    logic [31:0] din;
    obs_e        obs;
    int          idx;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    obs_e        obs;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic drive(input logic [26:0] c, input logic [31:0] din);
    dpi.PCout      = c[0];  dpi.Zlowout   = c[1];  dpi.MDRout    = c[2];
    dpi.Rout       = c[3];  dpi.BAout     = c[4];  dpi.InPortout = c[5];
    dpi.Csignout   = c[6];  dpi.PCin      = c[7];  dpi.IRin      = c[8];
    dpi.Yin        = c[9];  dpi.MARin     = c[10]; dpi.MDRin     = c[11];
    dpi.Zlowin     = c[12]; dpi.Zhighin   = c[13]; dpi.Rin       = c[14];
    dpi.CONin      = c[15]; dpi.Out_Portin = c[16]; dpi.MAR_clear = c[17];
    dpi.MD_read    = c[18]; dpi.Read      = c[19]; dpi.Write     = c[20];
    dpi.Gra        = c[21]; dpi.Grb       = c[22]; dpi.IncPC     = c[23];
    dpi.ADD        = c[24]; dpi.AND       = c[25]; dpi.Strobe    = c[26];
    dpi.INPUT_UNIT = din;
  endtask

  function automatic logic [63:0] obs_val(input obs_e o, input int idx);
    logic [3:0] k;
    k = idx[3:0];
    case (o)
      O_PC:    return {32'd0, dut.pc_q};
      O_IR:    return {32'd0, dut.ir_q};
      O_Y:     return {32'd0, dut.y_q};
      O_Z:     return dut.z_q;
      O_MAR:   return {32'd0, dut.mar_q};
      O_MDR:   return {32'd0, dut.mdr_q};
      O_OUT:   return {32'd0, dpi.OUTPUT_UNIT};
      O_CON:   return {63'd0, dpi.CONFF};
      O_BR:    return {63'd0, dpi.BRANCH};
      O_REG:   return {32'd0, dut.r_q[k]};
      O_BUS:   return {32'd0, dut.bus};
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic [26:0] c, input logic [31:0] din,
                      input obs_e o, input int idx, input logic [63:0] e);
    exp_t ex;
    drive(c, din);
    if (o != O_NONE) begin
      ex.name = nm; ex.obs = o; ex.idx = idx; ex.exp = e;
      sb.push_back(ex);
    end
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      check(ex.name, obs_val(ex.obs, ex.idx), ex.exp);
    end
  endtask

  task automatic add(input string nm, input logic [26:0] c, input logic [31:0] din,
                     input obs_e o, input int idx, input logic [63:0] e);
    vec_t v;
    v.name = nm; v.ctl = c; v.din = din; v.obs = o; v.idx = idx; v.exp = e;
    vt.push_back(v);
  endtask

  initial begin
    // RAM image written through the datapath, then fetch/IO/ALU/CON/BAout flows.
    add("ld_in",      STB,               32'hB0800000, O_NONE, 0, 0);
    add("mdr_bus",    INO|MDRI|MCLR,     0,            O_MDR,  0, 64'hB0800000);
    add("ram0_wr",    WR|STB,            32'h1,        O_NONE, 0, 0);
    add("mar_bus",    INO|MARI|STB,      32'hB8800000, O_MAR,  0, 64'h1);
    add("mdr2",       INO|MDRI,          0,            O_MDR,  0, 64'hB8800000);
    add("ram1_wr",    WR|STB,            32'h201,      O_NONE, 0, 0);
    add("mar_hi",     INO|MARI|MDRI,     0,            O_MAR,  0, 64'h201);
    add("rd_alias",   MDRI|MDRD|RD,      0,            O_MDR,  0, 64'hB8800000);
    add("marclr_pri", INO|MARI|MCLR,     0,            O_MAR,  0, 64'h0);
    add("mdr_hold",   MDRI|MDRD,         0,            O_MDR,  0, 64'hB8800000);
    add("f1_mar",     PCO|MARI|INC|ZLI,  0,            O_MAR,  0, 64'h0);
    add("f1_z",       0,                 0,            O_Z,    0, 64'h1);
    add("f2_pc",      ZLO|PCIN|RD|MDRD|MDRI, 0,        O_PC,   0, 64'h1);
    add("f2_mdr",     0,                 0,            O_MDR,  0, 64'hB0800000);
    add("f3_ir",      MDRO|IRIN,         0,            O_IR,   0, 64'hB0800000);
    add("in_stb",     STB,               32'h13868904, O_NONE, 0, 0);
    add("in_r1",      INO|GRA|RIN,       0,            O_REG,  1, 64'h13868904);
    add("g1_mar",     PCO|MARI|INC|ZLI,  0,            O_MAR,  0, 64'h1);
    add("g2_pc",      ZLO|PCIN|RD|MDRD|MDRI, 0,        O_PC,   0, 64'h2);
    add("g3_ir",      MDRO|IRIN,         0,            O_IR,   0, 64'hB8800000);
    add("out_port",   GRA|RO|OPI,        0,            O_OUT,  0, 64'h13868904);
    add("ir_ab",      STB,               32'h01900000, O_NONE, 0, 0);
    add("ir_ab_ld",   INO|IRIN,          0,            O_IR,   0, 64'h01900000);
    add("r2_stb",     STB,               32'h5,        O_NONE, 0, 0);
    add("r2_ld",      INO|GRB|RIN,       0,            O_REG,  2, 64'h5);
    add("r3_stb",     STB,               32'hFFFFFFFF, O_NONE, 0, 0);
    add("r3_ld",      INO|GRA|RIN,       0,            O_REG,  3, 64'hFFFFFFFF);
    add("y_r2",       GRB|RO|YIN,        0,            O_Y,    0, 64'h5);
    add("add_carry",  GRA|RO|ADDO|ZLI|ZHI, 0,          O_Z,    0, 64'h1_00000004);
    add("and_a",      STB,               32'hF0F0F0F0, O_NONE, 0, 0);
    add("and_y",      INO|YIN,           0,            O_Y,    0, 64'hF0F0F0F0);
    add("and_b",      STB,               32'h0FF00FF0, O_NONE, 0, 0);
    add("and_zlo",    INO|ANDO|ZLI,      0,            O_Z,    0, 64'h1_00F000F0);
    add("inc_stb",    STB,               32'hFFFFFFFF, O_NONE, 0, 0);
    add("inc_wrap",   INO|INC|ZLI|ZHI,   0,            O_Z,    0, 64'h0);
    add("add_pri",    INO|ADDO|ANDO|ZLI|ZHI, 0,        O_Z,    0, 64'h1_F0F0F0EF);
    add("bus_pc",     PCO|ZLO|MDRO|INO|YIN, 0,         O_Y,    0, 64'h2);
    add("bus_z",      ZLO|MDRO|INO|YIN,  0,            O_Y,    0, 64'hF0F0F0EF);
    add("bus_mdr",    MDRO|INO|RO|YIN,   0,            O_Y,    0, 64'hB8800000);
    add("bus_none",   YIN,               0,            O_Y,    0, 64'h0);
    add("cs_stb",     STB,               32'h00040001, O_NONE, 0, 0);
    add("cs_ir",      INO|IRIN,          0,            O_IR,   0, 64'h00040001);
    add("csign",      CSO|YIN,           0,            O_Y,    0, 64'hFFFC0001);
    add("br_stb",     STB,               32'h90800000, O_NONE, 0, 0);
    add("br_ir",      INO|IRIN,          0,            O_IR,   0, 64'h90800000);
    add("r1z_stb",    STB,               32'h0,        O_NONE, 0, 0);
    add("r1z_ld",     INO|GRA|RIN,       0,            O_REG,  1, 64'h0);
    add("con_eq0",    GRA|RO|CONI,       0,            O_CON,  0, 64'h1);
    add("branch_1",   0,                 0,            O_BR,   0, 64'h1);
    add("r17_stb",    STB,               32'h7,        O_NONE, 0, 0);
    add("r17_ld",     INO|GRA|RIN,       0,            O_REG,  1, 64'h7);
    add("con_ne",     GRA|RO|CONI,       0,            O_CON,  0, 64'h0);
    add("branch_0",   0,                 0,            O_BR,   0, 64'h0);
    add("c11_stb",    STB,               32'h90980000, O_NONE, 0, 0);
    add("c11_ir",     INO|IRIN,          0,            O_IR,   0, 64'h90980000);
    add("neg_stb",    STB,               32'h80000000, O_NONE, 0, 0);
    add("neg_ld",     INO|GRA|RIN,       0,            O_REG,  1, 64'h80000000);
    add("con_neg",    GRA|RO|CONI,       0,            O_CON,  0, 64'h1);
    add("branch_neg", 0,                 0,            O_BR,   0, 64'h1);
    add("op_stb",     STB,               32'h00980000, O_NONE, 0, 0);
    add("op_ir",      INO|IRIN,          0,            O_IR,   0, 64'h00980000);
    add("branch_op",  0,                 0,            O_BR,   0, 64'h0);
    add("ir0_stb",    STB,               32'h0,        O_NONE, 0, 0);
    add("ir0_ld",     INO|IRIN,          0,            O_IR,   0, 64'h0);
    add("r0_stb",     STB,               32'h12345678, O_NONE, 0, 0);
    add("r0_ld",      INO|GRA|RIN,       0,            O_REG,  0, 64'h12345678);
    add("baout_r0",   GRA|BAO|YIN,       0,            O_Y,    0, 64'h0);
    add("rout_r0",    GRA|RO|YIN,        0,            O_Y,    0, 64'h12345678);
    add("ba1_stb",    STB,               32'h00800000, O_NONE, 0, 0);
    add("ba1_ir",     INO|IRIN,          0,            O_IR,   0, 64'h00800000);
    add("baout_r1",   GRA|BAO|YIN,       0,            O_Y,    0, 64'h80000000);

    // Reset held with random strobes: everything must stay at zero.
    clear = 1'b0;
    drive(27'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(27'($urandom()), $urandom());
      @(posedge clock);
      #1;
    end
    check("rst_pc",  obs_val(O_PC, 0),  64'd0);
    check("rst_ir",  obs_val(O_IR, 0),  64'd0);
    check("rst_y",   obs_val(O_Y, 0),   64'd0);
    check("rst_z",   obs_val(O_Z, 0),   64'd0);
    check("rst_mar", obs_val(O_MAR, 0), 64'd0);
    check("rst_mdr", obs_val(O_MDR, 0), 64'd0);
    check("rst_in",  {32'd0, dut.inport_q}, 64'd0);
    check("rst_out", obs_val(O_OUT, 0), 64'd0);
    check("rst_con", obs_val(O_CON, 0), 64'd0);
    for (int i = 0; i < 16; i++)
      check($sformatf("rst_r%0d", i), obs_val(O_REG, i), 64'd0);

    drive(27'd0, 32'd0);
    clear = 1'b1;
    step("rst_bus", PCO, 0, O_BUS, 0, 64'd0);

    foreach (vt[i]) step(vt[i].name, vt[i].ctl, vt[i].din, vt[i].obs, vt[i].idx, vt[i].exp);

    // Simultaneous Read and Write at MAR=1: MDR takes the old word, RAM the new one.
    step("rw_stb",  STB,               32'hCAFEF00D, O_NONE, 0, 0);
    step("rw_mdr",  INO|MDRI,          0,            O_MDR,  0, 64'hCAFEF00D);
    step("rw_both", WR|RD|MDRD|MDRI,   0,            O_MDR,  0, 64'hB8800000);
    step("rw_new",  RD|MDRD|MDRI,      0,            O_MDR,  0, 64'hCAFEF00D);
    drive(27'd0, 32'd0);

    // Clear asserted between clock edges must take effect immediately.
    #2;
    clear = 1'b0;
    #1;
    check("async_pc",  obs_val(O_PC, 0),  64'd0);
    check("async_out", obs_val(O_OUT, 0), 64'd0);
    check("async_con", obs_val(O_CON, 0), 64'd0);
    check("async_r3",  obs_val(O_REG, 3), 64'd0);
    @(posedge clock);
    #1;
    clear = 1'b1;

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_left actual=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
